// File: rtl/nn_stream_pkg.sv
// Shared constants and capture FSM state type for the inference stream datapath.
// The image loader uses the same NN_DATA_W so both ends of the network agree on word size.
package nn_stream_pkg;

    localparam int NN_DATA_W = 32;
    localparam int NN_N_OUT  = 10;
    localparam int NN_IDX_W  = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DONE    = 2'd2
    } cap_state_t;

endpackage

// File: rtl/result_buffer_ram.sv
// Simple dual-port score buffer: one write port, one registered read-first read port.
// Storage is left unreset so it maps onto distributed or block RAM.
module result_buffer_ram #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 10,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd_data_d;
    logic [DATA_W-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Addresses past the last class read as zero instead of indexing off the array.
    always_comb begin
        rd_data_d = '0;
        if (rd_addr <= LAST_ADDR) begin
            rd_data_d = mem_q[rd_addr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/result_capture_module.sv
// Stream sink for the network's class scores: buffers them for readback and
// tracks the running argmax, flagging completion and tlast framing errors.
module result_capture_module
    import nn_stream_pkg::*;
#(
    parameter int DATA_W = NN_DATA_W,
    parameter int N_OUT  = NN_N_OUT,
    parameter int IDX_W  = NN_IDX_W
) (
    input  logic              s_axi_aclk,
    input  logic              s_axi_areset,
    input  logic              start,
    input  logic [DATA_W-1:0] y_tdata,
    input  logic              y_tvalid,
    input  logic              y_tlast,
    output logic              y_tready,
    input  logic [IDX_W-1:0]  rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [IDX_W-1:0]  class_idx,
    output logic [DATA_W-1:0] class_max,
    output logic [IDX_W:0]    beat_cnt
);

    localparam int             CNT_W    = IDX_W + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_OUT - 1);

    cap_state_t               state_q, state_d;
    logic                     start_q;
    logic                     ready_q, ready_d;
    logic                     done_q, done_d;
    logic                     err_q, err_d;
    logic [IDX_W-1:0]         class_idx_q, class_idx_d;
    logic signed [DATA_W-1:0] class_max_q, class_max_d;
    logic [CNT_W-1:0]         beat_cnt_q, beat_cnt_d;

    logic                     rise;
    logic                     beat_fire;
    logic                     at_last;
    logic signed [DATA_W-1:0] score;

    assign rise      = start & ~start_q;
    assign beat_fire = y_tvalid & ready_q;
    assign at_last   = (beat_cnt_q == CNT_LAST);
    assign score     = $signed(y_tdata);

    always_comb begin
        state_d     = state_q;
        done_d      = done_q;
        err_d       = err_q;
        class_idx_d = class_idx_q;
        class_max_d = class_max_q;
        beat_cnt_d  = beat_cnt_q;

        case (state_q)
            IDLE, DONE: begin
                if (rise) begin
                    state_d     = CAPTURE;
                    done_d      = 1'b0;
                    err_d       = 1'b0;
                    class_idx_d = '0;
                    class_max_d = '0;
                    beat_cnt_d  = '0;
                end
            end
            CAPTURE: begin
                if (beat_fire) begin
                    beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    // Strict compare: on a tie the earlier (lower) class index wins.
                    if ((beat_cnt_q == '0) || (score > class_max_q)) begin
                        class_idx_d = beat_cnt_q[IDX_W-1:0];
                        class_max_d = score;
                    end
                    // tlast and the beat count must agree; either one alone ends the frame.
                    if (y_tlast || at_last) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        err_d   = (y_tlast != at_last);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        ready_d = (state_d == CAPTURE);
    end

    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            state_q     <= IDLE;
            start_q     <= 1'b0;
            ready_q     <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            class_idx_q <= '0;
            class_max_q <= '0;
            beat_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            start_q     <= start;
            ready_q     <= ready_d;
            done_q      <= done_d;
            err_q       <= err_d;
            class_idx_q <= class_idx_d;
            class_max_q <= class_max_d;
            beat_cnt_q  <= beat_cnt_d;
        end
    end

    result_buffer_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (N_OUT),
        .ADDR_W (IDX_W)
    ) u_buf (
        .clk     (s_axi_aclk),
        .rst     (s_axi_areset),
        .wr_en   (beat_fire),
        .wr_addr (beat_cnt_q[IDX_W-1:0]),
        .wr_data (y_tdata),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    assign y_tready  = ready_q;
    assign busy      = (state_q == CAPTURE);
    assign done      = done_q;
    assign err       = err_q;
    assign class_idx = class_idx_q;
    assign class_max = class_max_q;
    assign beat_cnt  = beat_cnt_q;

endmodule

// File: tb/tb_result_capture_module.sv
// Directed bench for result_capture_module: a queue-based reference model checked
// every cycle, plus literal expectations for the documented scenarios.
module tb_result_capture_module;

    localparam int DATA_W = 32;
    localparam int N_OUT  = 10;
    localparam int IDX_W  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [DATA_W-1:0] y_tdata;
    logic              y_tvalid;
    logic              y_tlast;
    logic              y_tready;
    logic [IDX_W-1:0]  rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              busy;
    logic              done;
    logic              err;
    logic [IDX_W-1:0]  class_idx;
    logic [DATA_W-1:0] class_max;
    logic [IDX_W:0]    beat_cnt;

    int checks = 0;
    int errors = 0;

    result_capture_module #(.DATA_W(DATA_W), .N_OUT(N_OUT), .IDX_W(IDX_W)) dut (
        .s_axi_aclk   (clk),
        .s_axi_areset (rst),
        .start        (start),
        .y_tdata      (y_tdata),
        .y_tvalid     (y_tvalid),
        .y_tlast      (y_tlast),
        .y_tready     (y_tready),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .class_idx    (class_idx),
        .class_max    (class_max),
        .beat_cnt     (beat_cnt)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int                       m_phase = 0;       // 0 idle, 1 capturing, 2 result held
    logic                     m_start_prev = 1'b0;
    logic signed [DATA_W-1:0] m_scores[$];
    logic [DATA_W-1:0]        m_buf[N_OUT];
    bit                       m_known[N_OUT];
    logic                     m_done = 1'b0;
    logic                     m_err = 1'b0;
    logic [DATA_W-1:0]        m_rd = '0;
    bit                       m_rd_known = 1'b1;

    function automatic void model_argmax(output int idx, output logic [DATA_W-1:0] mx);
        logic signed [DATA_W-1:0] best;
        idx  = 0;
        best = '0;
        foreach (m_scores[i]) begin
            if (i == 0 || m_scores[i] > best) begin
                idx  = i;
                best = m_scores[i];
            end
        end
        mx = best;
    endfunction

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_phase = 0; m_start_prev = 1'b0; m_scores.delete();
                m_done = 1'b0; m_err = 1'b0; m_rd = '0; m_rd_known = 1'b1;
            end else begin
                if (int'(rd_addr) < N_OUT) begin
                    m_rd = m_buf[rd_addr]; m_rd_known = m_known[rd_addr];
                end else begin
                    m_rd = '0; m_rd_known = 1'b1;
                end
                if (m_phase == 1) begin
                    if (y_tvalid) begin
                        m_buf[m_scores.size()]   = y_tdata;
                        m_known[m_scores.size()] = 1'b1;
                        m_scores.push_back($signed(y_tdata));
                        if (y_tlast || m_scores.size() == N_OUT) begin
                            m_phase = 2;
                            m_done  = 1'b1;
                            m_err   = (y_tlast != (m_scores.size() == N_OUT));
                        end
                    end
                end else if (start && !m_start_prev) begin
                    m_phase = 1; m_scores.delete(); m_done = 1'b0; m_err = 1'b0;
                end
                m_start_prev = start;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- per-cycle compare ----------------
    initial begin
        int               e_idx;
        logic [DATA_W-1:0] e_max;
        forever begin
            @(negedge clk);
            model_argmax(e_idx, e_max);
            chk("y_tready", 32'(y_tready), 32'(m_phase == 1));
            chk("busy", 32'(busy), 32'(m_phase == 1));
            chk("done", 32'(done), 32'(m_done));
            chk("err", 32'(err), 32'(m_err));
            chk("beat_cnt", 32'(beat_cnt), 32'(m_scores.size()));
            chk("class_idx", 32'(class_idx), 32'(e_idx));
            chk("class_max", class_max, e_max);
            if (m_rd_known) chk("rd_data", rd_data, m_rd);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1; tick();
        start = 1'b0; tick();
    endtask

    task automatic send_beat(input logic [DATA_W-1:0] d, input logic last);
        int   n = 0;
        logic acc;
        y_tdata = d; y_tvalid = 1'b1; y_tlast = last;
        do begin
            @(negedge clk);
            acc = y_tready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 100);
        if (!acc) begin
            checks++; errors++;
            $display("FAIL beat_timeout actual=no_ready required=ready at %0t", $time);
        end
        y_tvalid = 1'b0; y_tlast = 1'b0;
    endtask

    task automatic send_frame(input int vals[], input int last_at, input bit gaps, input int restart_at);
        for (int i = 0; i < vals.size(); i++) begin
            if (gaps) repeat ($urandom_range(0, 3)) tick();
            if (i == restart_at) begin
                start = 1'b1; tick();
                start = 1'b0; tick();
            end
            send_beat(32'(vals[i]), i == last_at);
        end
    endtask

    int f1[] = '{5, -3, 12, 7, 12, 0, -1, 4, 9, 2};
    int f2[] = '{-8, -2, -9, -10, -7, -6, -4, -3, -11, -5};
    int f3[] = '{1, 2, 3, 4};
    int f5a[] = '{1, 2, 3, 4, 5};
    int f5b[] = '{3, 3, 1, 8, 2, 8, 0, -5, 7, 6};
    int f6[] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

    initial begin
        rst = 1'b1; start = 1'b0; y_tdata = '0; y_tvalid = 1'b0; y_tlast = 1'b0; rd_addr = '0;
        repeat (3) tick();
        @(negedge clk);
        chk("rst_ready", 32'(y_tready), 32'd0);
        chk("rst_beat_cnt", 32'(beat_cnt), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // 1: basic frame, tie at index 4 keeps index 2
        pulse_start();
        send_frame(f1, 9, 1'b0, -1);
        @(negedge clk);
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_err", 32'(err), 32'd0);
        chk("t1_idx", 32'(class_idx), 32'd2);
        chk("t1_max", class_max, 32'd12);
        chk("t1_beats", 32'(beat_cnt), 32'd10);
        tick();

        // 2: all negative, then readback sweep including out-of-range
        pulse_start();
        send_frame(f2, 9, 1'b0, -1);
        @(negedge clk);
        chk("t2_idx", 32'(class_idx), 32'd1);
        chk("t2_max", class_max, 32'hFFFF_FFFE);
        tick();
        rd_addr = 4'd1; tick();
        @(negedge clk);
        chk("t2_rd1", rd_data, 32'hFFFF_FFFE);
        tick();
        for (int a = 0; a < 16; a++) begin
            rd_addr = 4'(a); tick();
        end
        rd_addr = 4'd12; tick();
        @(negedge clk);
        chk("t2_rd_oob", rd_data, 32'd0);
        tick();
        rd_addr = 4'd0;

        // 3: early tlast on the fourth beat
        pulse_start();
        send_frame(f3, 3, 1'b0, -1);
        @(negedge clk);
        chk("t3_err", 32'(err), 32'd1);
        chk("t3_done", 32'(done), 32'd1);
        chk("t3_beats", 32'(beat_cnt), 32'd4);
        chk("t3_ready", 32'(y_tready), 32'd0);
        tick();

        // 4: gaps plus a start rise mid-capture
        pulse_start();
        send_frame(f1, 9, 1'b1, 5);
        @(negedge clk);
        chk("t4_idx", 32'(class_idx), 32'd2);
        chk("t4_max", class_max, 32'd12);
        chk("t4_beats", 32'(beat_cnt), 32'd10);
        chk("t4_err", 32'(err), 32'd0);
        tick();

        // 5: reset mid-capture, then a clean frame
        pulse_start();
        send_frame(f5a, -1, 1'b0, -1);
        rst = 1'b1;
        #1;
        chk("t5_ready", 32'(y_tready), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_beats", 32'(beat_cnt), 32'd0);
        chk("t5_max", class_max, 32'd0);
        chk("t5_rd", rd_data, 32'd0);
        tick(); tick();
        rst = 1'b0;
        tick();
        pulse_start();
        send_frame(f5b, 9, 1'b0, -1);
        @(negedge clk);
        chk("t5_idx", 32'(class_idx), 32'd3);
        chk("t5_max2", class_max, 32'd8);
        chk("t5_err", 32'(err), 32'd0);
        tick();

        // 6: start held high across DONE; missing tlast on beat ten
        start = 1'b1; tick();
        send_frame(f6, -1, 1'b0, -1);
        repeat (3) tick();
        @(negedge clk);
        chk("t6_busy_held", 32'(busy), 32'd0);
        chk("t6_done_held", 32'(done), 32'd1);
        chk("t6_err_missing", 32'(err), 32'd1);
        chk("t6_idx_ties", 32'(class_idx), 32'd0);
        tick();
        start = 1'b0; tick();
        start = 1'b1; tick();
        @(negedge clk);
        chk("t6_done_clr", 32'(done), 32'd0);
        chk("t6_err_clr", 32'(err), 32'd0);
        chk("t6_busy", 32'(busy), 32'd1);
        tick();
        start = 1'b0;
        send_frame(f1, 9, 1'b0, -1);
        repeat (2) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
